// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-requester ALU arbiter: FSM states, requester count and ALU opcode set.
// The legal-opcode helper exists only when ALU_ARB_ILLEGAL_OP_EN is defined.
package alu_arbiter_pkg;

  localparam int NREQ  = 2;
  localparam int OPS_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  // Opcode mnemonics understood by the shared ALU; encodings 11..15 are unused.
  typedef enum logic [OPS_W-1:0] {
    kADD = 4'd0,
    kSUB = 4'd1,
    kAND = 4'd2,
    kOR  = 4'd3,
    kXOR = 4'd4,
    kSHL = 4'd5,
    kSHR = 4'd6,
    kBEQ = 4'd7,
    kBNE = 4'd8,
    kBLT = 4'd9,
    kBGT = 4'd10
  } op_mne;

`ifdef ALU_ARB_ILLEGAL_OP_EN
  function automatic logic op_legal(input logic [OPS_W-1:0] op);
    return op inside {kADD, kSUB, kAND, kOR, kXOR, kSHL, kSHR, kBEQ, kBNE, kBLT, kBGT};
  endfunction
`endif

endpackage

// File: rtl/alu_arb_rr.sv
// Two-way round-robin picker: a lone request always wins; on a tie the requester
// not named by the last-granted pointer wins. Purely combinational.
module alu_arb_rr
  import alu_arbiter_pkg::*;
(
  input  logic [NREQ-1:0] req_valid_i,
  input  logic            ptr_i,
  output logic [NREQ-1:0] grant_o
);

  assign grant_o[0] = req_valid_i[0] & (~req_valid_i[1] | ptr_i);
  assign grant_o[1] = req_valid_i[1] & (~req_valid_i[0] | ~ptr_i);

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter/sequencer in front of the shared combinational ALU: accept, register operands,
// capture the result, hold it for the owner. ALU_ARB_ILLEGAL_OP_EN enables the illegal-opcode RspErr path.
//
// Handshake: a request transfers in the cycle ReqValid[i] && ReqReady[i]; the requester keeps
// ReqOp/ReqA/ReqB stable until then. A response transfers when RspValid[i] && RspReady[i];
// RspOut/RspJump/RspErr stay stable while RspValid is high.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int W   = 8,
  parameter int Ops = 4
) (
  input  logic                     Clk,
  input  logic                     Reset_n,
  input  logic [NREQ-1:0]          ReqValid,
  output logic [NREQ-1:0]          ReqReady,
  input  logic [NREQ-1:0][Ops-1:0] ReqOp,
  input  logic [NREQ-1:0][W-1:0]   ReqA,
  input  logic [NREQ-1:0][W-1:0]   ReqB,
  output logic [NREQ-1:0]          RspValid,
  input  logic [NREQ-1:0]          RspReady,
  output logic [W-1:0]             RspOut,
  output logic                     RspJump,
  output logic                     RspErr,
  output logic [W-1:0]             AluA,
  output logic [W-1:0]             AluB,
  output logic [Ops-1:0]           AluOp,
  input  logic [W-1:0]             AluOut,
  input  logic                     AluJump,
  output arb_state_t               dbg_state_o
);

  arb_state_t      state_q;
  logic            ptr_q;
  logic            owner_q;
  logic [NREQ-1:0] rsp_valid_q;
  logic [W-1:0]    rsp_out_q;
  logic            rsp_jump_q;
  logic [W-1:0]    alu_a_q;
  logic [W-1:0]    alu_b_q;
  logic [Ops-1:0]  alu_op_q;

  logic [NREQ-1:0] grant;
  logic            rsp_hs;
  logic            can_accept;
  logic            accept;
  logic            win;
  logic [W-1:0]    cap_out;
  logic            cap_jump;

  alu_arb_rr u_rr (
    .req_valid_i (ReqValid),
    .ptr_i       (ptr_q),
    .grant_o     (grant)
  );

  // A new op may be taken from IDLE, or from RESP in the same cycle the current result is taken.
  assign rsp_hs     = |(rsp_valid_q & RspReady);
  assign can_accept = (state_q == IDLE) || ((state_q == RESP) && rsp_hs);
  assign ReqReady   = can_accept ? grant : '0;
  assign accept     = |ReqReady;
  assign win        = grant[1];

`ifdef ALU_ARB_ILLEGAL_OP_EN
  logic err_pend_q;
  logic rsp_err_q;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      err_pend_q <= 1'b0;
      rsp_err_q  <= 1'b0;
    end else begin
      if (accept) err_pend_q <= !op_legal(ReqOp[win]);
      if (state_q == EXEC) rsp_err_q <= err_pend_q;
    end
  end

  assign cap_out  = err_pend_q ? '0 : AluOut;
  assign cap_jump = err_pend_q ? 1'b0 : AluJump;
  assign RspErr   = rsp_err_q;
`else
  assign cap_out  = AluOut;
  assign cap_jump = AluJump;
  assign RspErr   = 1'b0;
`endif

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= IDLE;
      ptr_q       <= 1'b1;
      owner_q     <= 1'b0;
      rsp_valid_q <= '0;
      rsp_out_q   <= '0;
      rsp_jump_q  <= 1'b0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= '0;
    end else begin
      if (accept) begin
        alu_op_q <= ReqOp[win];
        alu_a_q  <= ReqA[win];
        alu_b_q  <= ReqB[win];
        owner_q  <= win;
        ptr_q    <= win;
      end
      case (state_q)
        IDLE: begin
          if (accept) state_q <= EXEC;
        end
        EXEC: begin
          rsp_out_q   <= cap_out;
          rsp_jump_q  <= cap_jump;
          rsp_valid_q <= owner_q ? 2'b10 : 2'b01;
          state_q     <= RESP;
        end
        RESP: begin
          if (rsp_hs) begin
            rsp_valid_q <= '0;
            state_q     <= accept ? EXEC : IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign RspValid    = rsp_valid_q;
  assign RspOut      = rsp_out_q;
  assign RspJump     = rsp_jump_q;
  assign AluA        = alu_a_q;
  assign AluB        = alu_b_q;
  assign AluOp       = alu_op_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ALU model; hand-computed expectations
// checked by immediate assertions. Honours ALU_ARB_ILLEGAL_OP_EN for the illegal-opcode case.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  logic             Clk;
  logic             Reset_n;
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [1:0][3:0]  req_op;
  logic [1:0][7:0]  req_a;
  logic [1:0][7:0]  req_b;
  logic [1:0]       rsp_valid;
  logic [1:0]       rsp_ready;
  logic [7:0]       rsp_out;
  logic             rsp_jump;
  logic             rsp_err;
  logic [7:0]       alu_a;
  logic [7:0]       alu_b;
  logic [3:0]       alu_op;
  logic [7:0]       alu_out;
  logic             alu_jump;
  arb_state_t       dbg_state;

  int n_chk  = 0;
  int n_pass = 0;

  alu_arbiter #(.W(8), .Ops(4)) dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .ReqValid    (req_valid),
    .ReqReady    (req_ready),
    .ReqOp       (req_op),
    .ReqA        (req_a),
    .ReqB        (req_b),
    .RspValid    (rsp_valid),
    .RspReady    (rsp_ready),
    .RspOut      (rsp_out),
    .RspJump     (rsp_jump),
    .RspErr      (rsp_err),
    .AluA        (alu_a),
    .AluB        (alu_b),
    .AluOp       (alu_op),
    .AluOut      (alu_out),
    .AluJump     (alu_jump),
    .dbg_state_o (dbg_state)
  );

  // Clock and behavioural ALU
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  always_comb begin
    alu_out  = 8'h00;
    alu_jump = 1'b0;
    case (alu_op)
      kADD: alu_out = alu_a + alu_b;
      kSUB: alu_out = alu_a - alu_b;
      kAND: alu_out = alu_a & alu_b;
      kOR:  alu_out = alu_a | alu_b;
      kXOR: alu_out = alu_a ^ alu_b;
      kSHL: alu_out = alu_a << alu_b[2:0];
      kSHR: alu_out = alu_a >> alu_b[2:0];
      kBEQ: begin alu_jump = (alu_a == alu_b); alu_out = {7'd0, alu_jump}; end
      kBNE: begin alu_jump = (alu_a != alu_b); alu_out = {7'd0, alu_jump}; end
      kBLT: begin alu_jump = (alu_a <  alu_b); alu_out = {7'd0, alu_jump}; end
      kBGT: begin alu_jump = (alu_a >  alu_b); alu_out = {7'd0, alu_jump}; end
      default: begin alu_out = 8'hA5; alu_jump = 1'b1; end
    endcase
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  logic [1:0] exp_g [4];
  logic [7:0] exp_illegal_out;
  logic       exp_illegal_jump;
  logic       exp_illegal_err;

  initial begin
    exp_g[0] = 2'b10; exp_g[1] = 2'b01; exp_g[2] = 2'b10; exp_g[3] = 2'b01;
`ifdef ALU_ARB_ILLEGAL_OP_EN
    exp_illegal_out = 8'h00; exp_illegal_jump = 1'b0; exp_illegal_err = 1'b1;
`else
    exp_illegal_out = 8'hA5; exp_illegal_jump = 1'b1; exp_illegal_err = 1'b0;
`endif

    Reset_n   = 1'b0;
    req_valid = 2'b00;
    rsp_ready = 2'b11;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    step();
    step();

    // Reset state
    chk("rst_ready", 16'(req_ready), 16'h0);
    chk("rst_rspvalid", 16'(rsp_valid), 16'h0);
    chk("rst_rspout", 16'(rsp_out), 16'h0);
    chk("rst_jump", 16'(rsp_jump), 16'h0);
    chk("rst_err", 16'(rsp_err), 16'h0);
    chk("rst_alu", {alu_op, alu_a, 4'h0}, 16'h0);
    chk("rst_aluB", 16'(alu_b), 16'h0);
    chk("rst_state", 16'(dbg_state), 16'(IDLE));
    Reset_n = 1'b1;
    step();

    // Single ADD from requester 0
    req_op[0] = kADD; req_a[0] = 8'h12; req_b[0] = 8'h34; req_valid = 2'b01;
    #1 chk("add_ready", 16'(req_ready), 16'h1);
    step();
    req_valid = 2'b00;
    chk("add_exec_ready", 16'(req_ready), 16'h0);
    chk("add_exec_state", 16'(dbg_state), 16'(EXEC));
    chk("add_alu_a", 16'(alu_a), 16'h12);
    chk("add_alu_b", 16'(alu_b), 16'h34);
    chk("add_alu_op", 16'(alu_op), 16'(kADD));
    chk("add_rspvalid_exec", 16'(rsp_valid), 16'h0);
    step();
    chk("add_rspvalid", 16'(rsp_valid), 16'h1);
    chk("add_rspout", 16'(rsp_out), 16'h46);
    chk("add_jump", 16'(rsp_jump), 16'h0);
    step();
    chk("add_idle", 16'(dbg_state), 16'(IDLE));

    // Simultaneous requests straight out of reset
    Reset_n = 1'b0;
    step();
    Reset_n = 1'b1;
    step();
    req_op[0] = kSUB; req_a[0] = 8'd9; req_b[0] = 8'd4;
    req_op[1] = kBNE; req_a[1] = 8'd3; req_b[1] = 8'd3;
    req_valid = 2'b11;
    #1 chk("tie_ready0", 16'(req_ready), 16'h1);
    step();
    req_valid = 2'b10;
    chk("tie_exec_ready", 16'(req_ready), 16'h0);
    step();
    chk("tie_rspvalid0", 16'(rsp_valid), 16'h1);
    chk("tie_rspout0", 16'(rsp_out), 16'd5);
    chk("tie_b2b_ready1", 16'(req_ready), 16'h2);
    step();
    req_valid = 2'b00;
    chk("tie_exec2_state", 16'(dbg_state), 16'(EXEC));
    chk("tie_exec2_rspvalid", 16'(rsp_valid), 16'h0);
    step();
    chk("tie_rspvalid1", 16'(rsp_valid), 16'h2);
    chk("tie_rspout1", 16'(rsp_out), 16'd0);
    chk("tie_jump1", 16'(rsp_jump), 16'd0);
    step();

    // Backpressure on requester 1 while requester 0 waits
    rsp_ready = 2'b00;
    req_op[1] = kBGT; req_a[1] = 8'd200; req_b[1] = 8'd100;
    req_valid = 2'b10;
    #1 chk("bp_ready1", 16'(req_ready), 16'h2);
    step();
    req_op[0] = kADD; req_a[0] = 8'd1; req_b[0] = 8'd1;
    req_valid = 2'b01;
    #1 chk("bp_exec_ready", 16'(req_ready), 16'h0);
    step();
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold_valid", 16'(rsp_valid), 16'h2);
      chk("bp_hold_out", 16'(rsp_out), 16'd1);
      chk("bp_hold_jump", 16'(rsp_jump), 16'd1);
      chk("bp_hold_ready", 16'(req_ready), 16'h0);
      step();
    end
    rsp_ready = 2'b01;
    #1 chk("bp_wrong_rdy_ignored", 16'(req_ready), 16'h0);
    rsp_ready = 2'b10;
    #1 chk("bp_b2b_ready0", 16'(req_ready), 16'h1);
    step();
    req_valid = 2'b00;
    rsp_ready = 2'b11;
    chk("bp_exec_rspvalid", 16'(rsp_valid), 16'h0);
    step();
    chk("bp_rspvalid0", 16'(rsp_valid), 16'h1);
    chk("bp_rspout0", 16'(rsp_out), 16'd2);
    step();

    // Continuous requests from both: grants alternate starting opposite the last grant
    req_op[0] = kADD; req_a[0] = 8'd1;  req_b[0] = 8'd2;
    req_op[1] = kADD; req_a[1] = 8'd10; req_b[1] = 8'd20;
    req_valid = 2'b11;
    #1 chk("cont_ready_first", 16'(req_ready), 16'(exp_g[0]));
    for (int i = 0; i < 4; i++) begin
      step();
      chk("cont_exec_ready", 16'(req_ready), 16'h0);
      chk("cont_exec_rspvalid", 16'(rsp_valid), 16'h0);
      step();
      chk("cont_rspvalid", 16'(rsp_valid), 16'(exp_g[i]));
      chk("cont_rspout", 16'(rsp_out), (exp_g[i] == 2'b10) ? 16'd30 : 16'd3);
      if (i < 3) begin
        chk("cont_ready_next", 16'(req_ready), 16'(exp_g[i+1]));
      end else begin
        req_valid = 2'b00;
        #1 chk("cont_ready_end", 16'(req_ready), 16'h0);
      end
    end
    step();

    // Reset pulsed during EXEC discards the op and restores the pointer
    req_op[0] = kADD; req_a[0] = 8'd5; req_b[0] = 8'd5;
    req_valid = 2'b01;
    step();
    req_valid = 2'b00;
    chk("mid_exec_state", 16'(dbg_state), 16'(EXEC));
    chk("mid_exec_alu_a", 16'(alu_a), 16'd5);
    Reset_n = 1'b0;
    #1;
    chk("mid_rst_state", 16'(dbg_state), 16'(IDLE));
    chk("mid_rst_alu_a", 16'(alu_a), 16'd0);
    chk("mid_rst_alu_op", 16'(alu_op), 16'd0);
    chk("mid_rst_rspout", 16'(rsp_out), 16'd0);
    step();
    Reset_n = 1'b1;
    chk("mid_rst_rspvalid_a", 16'(rsp_valid), 16'h0);
    step();
    chk("mid_rst_rspvalid_b", 16'(rsp_valid), 16'h0);
    chk("mid_rst_idle", 16'(dbg_state), 16'(IDLE));
    req_valid = 2'b11;
    #1 chk("mid_rst_ptr", 16'(req_ready), 16'h1);
    step();
    req_valid = 2'b00;
    step();
    chk("mid_rst_rspvalid0", 16'(rsp_valid), 16'h1);
    chk("mid_rst_rspout0", 16'(rsp_out), 16'd10);
    step();

    // Unused opcode encoding, then a legal op
    req_op[1] = 4'hF; req_a[1] = 8'd1; req_b[1] = 8'd2;
    req_valid = 2'b10;
    step();
    req_valid = 2'b00;
    step();
    chk("ill_rspvalid", 16'(rsp_valid), 16'h2);
    chk("ill_rspout", 16'(rsp_out), 16'(exp_illegal_out));
    chk("ill_jump", 16'(rsp_jump), 16'(exp_illegal_jump));
    chk("ill_err", 16'(rsp_err), 16'(exp_illegal_err));
    step();
    req_op[1] = kADD; req_a[1] = 8'd1; req_b[1] = 8'd2;
    req_valid = 2'b10;
    step();
    req_valid = 2'b00;
    step();
    chk("legal_after_rspout", 16'(rsp_out), 16'd3);
    chk("legal_after_err", 16'(rsp_err), 16'd0);
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
